// File: rtl/cbfp_sf_fifo_if.sv
// ---------------------------------------------------------------------------
// cbfp_sf_fifo_if
// Bus bundle for the scaling-factor FIFO that sits between two CBFP stages.
//   clr       : synchronous flush
//   push      : write-block request, in_sf[NUM_IN] carries the lane factors
//   pop       : read request
//   out_sf    : DATA_OUT popped factors, out_min is their minimum
//   out_valid : one-cycle strobe marking a new out_sf/out_min
//   count     : stored entries, full/empty are decodes of count
//   ovf_err / udf_err : sticky rejected-push / rejected-pop flags
// The master modport is the side that issues push/pop, the slave is the FIFO.
// ---------------------------------------------------------------------------
interface cbfp_sf_fifo_if #(
  parameter int FACTOR_WIDTH = 5,
  parameter int NUM_IN       = 4,
  parameter int DATA_OUT     = 32,
  parameter int ADDR_WIDTH   = 9
);
  logic                    clr;
  logic                    push;
  logic [FACTOR_WIDTH-1:0] in_sf [NUM_IN];
  logic                    pop;
  logic [FACTOR_WIDTH-1:0] out_sf [DATA_OUT];
  logic [FACTOR_WIDTH-1:0] out_min;
  logic                    out_valid;
  logic [ADDR_WIDTH:0]     count;
  logic                    full;
  logic                    empty;
  logic                    ovf_err;
  logic                    udf_err;

  modport master (
    output clr, push, in_sf, pop,
    input  out_sf, out_min, out_valid, count, full, empty, ovf_err, udf_err
  );

  modport slave (
    input  clr, push, in_sf, pop,
    output out_sf, out_min, out_valid, count, full, empty, ovf_err, udf_err
  );
endinterface

// File: rtl/cbfp_sf_fifo.sv
// ---------------------------------------------------------------------------
// cbfp_sf_fifo
// Scaling-factor FIFO between CBFP stages. A push stores NUM_IN block
// exponents, each replicated IN_REP times (one write block of WB entries).
// A pop returns DATA_OUT consecutive factors plus their unsigned minimum.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset (pointers, count, flags, outputs)
//   bus  : cbfp_sf_fifo_if.slave (clr, push, in_sf, pop in; out_sf, out_min,
//          out_valid, count, full, empty, ovf_err, udf_err out)
// All outputs are registers or decodes of the registered count, so there is
// no combinational path from inputs to outputs.
// ---------------------------------------------------------------------------
module cbfp_sf_fifo #(
  parameter int FACTOR_WIDTH = 5,
  parameter int NUM_IN       = 4,
  parameter int IN_REP       = 8,
  parameter int DATA_OUT     = 32,
  parameter int DEPTH        = 512,
  parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  cbfp_sf_fifo_if.slave     bus
);

  localparam int WB = NUM_IN * IN_REP;

  localparam logic [ADDR_WIDTH:0]   FULL_THR  = (ADDR_WIDTH+1)'(DEPTH - WB);
  localparam logic [ADDR_WIDTH:0]   WB_C      = (ADDR_WIDTH+1)'(WB);
  localparam logic [ADDR_WIDTH:0]   DO_C      = (ADDR_WIDTH+1)'(DATA_OUT);
  localparam logic [ADDR_WIDTH-1:0] WB_PTR    = ADDR_WIDTH'(WB);
  localparam logic [ADDR_WIDTH-1:0] DO_PTR    = ADDR_WIDTH'(DATA_OUT);

  // Pointer wrap relies on natural overflow, and a write block / read window
  // must never straddle the wrap in a way that breaks block alignment.
  if (((DEPTH & (DEPTH - 1)) != 0) || ((DEPTH % WB) != 0) ||
      ((DEPTH % DATA_OUT) != 0)) begin : g_bad_cfg
    $error("cbfp_sf_fifo: DEPTH must be a power of 2 and a multiple of NUM_IN*IN_REP and DATA_OUT");
  end

  function automatic logic [FACTOR_WIDTH-1:0] min_factor(
    input logic [FACTOR_WIDTH-1:0] v [DATA_OUT]
  );
    logic [FACTOR_WIDTH-1:0] m;
    m = v[0];
    for (int k = 1; k < DATA_OUT; k++) begin
      if (v[k] < m) m = v[k];
    end
    return m;
  endfunction

  logic [FACTOR_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   wptr_q,    wptr_d;
  logic [ADDR_WIDTH-1:0]   rptr_q,    rptr_d;
  logic [ADDR_WIDTH:0]     count_q,   count_d;
  logic                    valid_q,   valid_d;
  logic                    ovf_q,     ovf_d;
  logic                    udf_q,     udf_d;
  logic [FACTOR_WIDTH-1:0] out_sf_q  [DATA_OUT];
  logic [FACTOR_WIDTH-1:0] out_sf_d  [DATA_OUT];
  logic [FACTOR_WIDTH-1:0] out_min_q, out_min_d;
  logic [FACTOR_WIDTH-1:0] rd_sf     [DATA_OUT];

  logic full, empty, push_ok, pop_ok;

  assign full    = (count_q > FULL_THR);
  assign empty   = (count_q < DO_C);
  // Acceptance uses the flags from before this edge; clr overrides both.
  assign push_ok = bus.push & ~full  & ~bus.clr;
  assign pop_ok  = bus.pop  & ~empty & ~bus.clr;

  // Read window: memory contents before this edge, so no write-through.
  always_comb begin
    for (int k = 0; k < DATA_OUT; k++) begin
      rd_sf[k] = mem_q[rptr_q + ADDR_WIDTH'(k)];
    end
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    out_sf_d  = out_sf_q;
    out_min_d = out_min_q;
    if (bus.clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (push_ok) wptr_d = wptr_q + WB_PTR;
      else if (bus.push) ovf_d = 1'b1;
      if (pop_ok) begin
        rptr_d    = rptr_q + DO_PTR;
        valid_d   = 1'b1;
        out_sf_d  = rd_sf;
        out_min_d = min_factor(rd_sf);
      end else if (bus.pop) begin
        udf_d = 1'b1;
      end
      count_d = count_q + (push_ok ? WB_C : '0) - (pop_ok ? DO_C : '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      out_min_q <= '0;
      for (int k = 0; k < DATA_OUT; k++) out_sf_q[k] <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      out_min_q <= out_min_d;
      out_sf_q  <= out_sf_d;
    end
  end

  // Storage is not reset; pop gating ensures only written entries are read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < NUM_IN; i++) begin
        for (int j = 0; j < IN_REP; j++) begin
          mem_q[wptr_q + ADDR_WIDTH'(i*IN_REP + j)] <= bus.in_sf[i];
        end
      end
    end
  end

  assign bus.out_sf    = out_sf_q;
  assign bus.out_min   = out_min_q;
  assign bus.out_valid = valid_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.ovf_err   = ovf_q;
  assign bus.udf_err   = udf_q;

endmodule
